// File: rtl/bios_port_arbiter_if.sv
// Request/response bundle between the MIPS150 fetch/load paths, the BIOS RAM and bios_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface bios_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic [31:0]       if_pc;
    logic              if_req;
    logic [31:0]       d_addr;
    logic              d_req;
    logic              bios_en;
    logic [ADDR_W-1:0] bios_addr;
    logic [31:0]       bios_dout;
    logic              if_stall;
    logic              d_stall;
    logic              if_rvalid;
    logic              d_rvalid;
    logic [31:0]       rdata;
    logic [15:0]       conflict_cnt;

    modport slave (
        input  if_pc, if_req, d_addr, d_req, bios_dout,
        output bios_en, bios_addr, if_stall, d_stall, if_rvalid, d_rvalid, rdata, conflict_cnt
    );

    modport master (
        output if_pc, if_req, d_addr, d_req, bios_dout,
        input  bios_en, bios_addr, if_stall, d_stall, if_rvalid, d_rvalid, rdata, conflict_cnt
    );
endinterface

// File: rtl/bios_port_arbiter.sv
// Shares the BIOS RAM read port between instruction fetch and data loads; data wins ties until
// MAX_D_BURST consecutive wins. Optional conflict counter enabled by macro BIOS_ARB_PERF_EN.
module bios_port_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int MAX_D_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    bios_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_BURST = 4'(MAX_D_BURST);

    owner_t     r_owner;
    owner_t     w_grant;
    logic [3:0] r_burst;
    logic [3:0] w_burst_nxt;
    logic       w_fq;
    logic       w_dq;

    assign w_fq = bus.if_req & (bus.if_pc[31:28] == 4'b0100);
    assign w_dq = bus.d_req  & (bus.d_addr[31:28] == 4'b0100);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= IDLE;
            r_burst <= 4'd0;
        end else begin
            r_owner <= w_grant;
            r_burst <= w_burst_nxt;
        end
    end

    always_comb begin
        w_grant       = IDLE;
        w_burst_nxt   = 4'd0;
        bus.bios_en   = 1'b0;
        bus.bios_addr = bus.if_pc[ADDR_W+1:2];
        bus.if_stall  = 1'b0;
        bus.d_stall   = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.rdata     = bus.bios_dout;

        if (w_dq && !w_fq) begin
            w_grant = DATA;
        end else if (w_fq && !w_dq) begin
            w_grant = FETCH;
        end else if (w_fq && w_dq) begin
            // The load is the older instruction, so it wins until fetch has waited long enough.
            w_grant = (r_burst == MAX_BURST) ? FETCH : DATA;
        end

        if (w_grant == DATA && w_fq) begin
            w_burst_nxt = (r_burst == MAX_BURST) ? MAX_BURST : r_burst + 4'd1;
        end

        if (w_grant == DATA) begin
            bus.bios_addr = bus.d_addr[ADDR_W+1:2];
        end

        if (!reset) begin
            bus.bios_en   = (w_grant != IDLE);
            bus.if_stall  = (w_grant == DATA)  && w_fq;
            bus.d_stall   = (w_grant == FETCH) && w_dq;
            bus.if_rvalid = (r_owner == FETCH);
            bus.d_rvalid  = (r_owner == DATA);
        end
    end

`ifdef BIOS_ARB_PERF_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= 16'd0;
        end else if (w_fq && w_dq && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign bus.conflict_cnt = r_conflict_cnt;
`else
    assign bus.conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bios_port_arbiter.sv
// Directed + randomized bench for bios_port_arbiter with a BIOS RAM model and a rule-level reference.
module tb_bios_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int MAXB   = 4;

    logic clk = 1'b0;
    logic reset;

    bios_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    bios_port_arbiter #(.ADDR_W(ADDR_W), .MAX_D_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Synchronous-read BIOS RAM.
    always @(posedge clk) begin
        if (bus.bios_en) bus.bios_dout <= mem[bus.bios_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference state: who was granted last cycle, at which word, and the data-win streak.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    int          m_streak = 0;
    int          m_conf = 0;
    logic [11:0] m_last_addr = '0;
    logic        last_if_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ireq, input logic [31:0] pc,
                        input logic dreq, input logic [31:0] da);
        bit fq, dq;
        int g;
        logic [11:0] ga;
        reset      = rst;
        bus.if_req = ireq;
        bus.if_pc  = pc;
        bus.d_req  = dreq;
        bus.d_addr = da;
        fq = ireq && (pc[31:28] == 4'h4);
        dq = dreq && (da[31:28] == 4'h4);
        if (dq && !fq)      g = 2;
        else if (fq && !dq) g = 1;
        else if (fq && dq)  g = (m_streak >= MAXB) ? 1 : 2;
        else                g = 0;
        ga = (g == 2) ? da[13:2] : pc[13:2];

        @(negedge clk);
        last_if_stall = bus.if_stall;
        if (rst) begin
            chk("bios_en_rst",   {31'd0, bus.bios_en},   32'd0);
            chk("if_stall_rst",  {31'd0, bus.if_stall},  32'd0);
            chk("d_stall_rst",   {31'd0, bus.d_stall},   32'd0);
            chk("if_rvalid_rst", {31'd0, bus.if_rvalid}, 32'd0);
            chk("d_rvalid_rst",  {31'd0, bus.d_rvalid},  32'd0);
        end else begin
            chk("bios_en",   {31'd0, bus.bios_en},   {31'd0, g != 0});
            chk("bios_addr", {20'd0, bus.bios_addr}, {20'd0, ga});
            chk("if_stall",  {31'd0, bus.if_stall},  {31'd0, (g == 2) && fq});
            chk("d_stall",   {31'd0, bus.d_stall},   {31'd0, (g == 1) && dq});
            chk("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, m_owner == 1});
            chk("d_rvalid",  {31'd0, bus.d_rvalid},  {31'd0, m_owner == 2});
            if (m_owner != 0) chk("rdata", bus.rdata, mem[m_last_addr]);
        end
`ifdef BIOS_ARB_PERF_EN
        chk("conflict_cnt", {16'd0, bus.conflict_cnt}, m_conf);
`else
        chk("conflict_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
`endif

        if (rst) begin
            m_owner  = 0;
            m_streak = 0;
            m_conf   = 0;
        end else begin
            m_owner     = g;
            m_last_addr = ga;
            m_streak    = (g == 2 && fq) ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
            if (fq && dq && m_conf < 65535) m_conf++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] pat;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        bus.bios_dout = '0;
        bus.if_req = 0; bus.d_req = 0; bus.if_pc = '0; bus.d_addr = '0;
        reset = 1;
        #1;

        step(1, 0, 32'h0, 0, 32'h0);
        step(1, 1, 32'h4000_0010, 1, 32'h4000_0020);

        // Fetch only: three back-to-back fetches, then an idle cycle to see the last return.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h4000_0010, 0, 32'h0);
        step(0, 0, 32'h4000_0010, 0, 32'h0);

        // Simultaneous requests: data wins.
        step(0, 1, 32'h4000_0000, 1, 32'h4000_0020);
        step(0, 0, 32'h4000_0000, 0, 32'h0);

        // Burst limit: both held for 6 cycles.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h4000_0100 + 32'(i*4), 1, 32'h4000_0200);
            pat[5-i] = last_if_stall;
        end
        chk("burst_pattern", {26'd0, pat}, {26'd0, 6'b111101});
        step(0, 0, 32'h0, 0, 32'h0);

        // Region decode: both requests outside the BIOS window.
        step(0, 1, 32'h1000_0000, 0, 32'h0);
        step(0, 1, 32'h1000_0000, 1, 32'h8000_0040);
        step(0, 0, 32'h0, 0, 32'h0);

        // Reset mid-read: data granted, then reset; no return afterwards.
        step(0, 1, 32'h4000_0000, 1, 32'h4000_0044);
        step(1, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 32'h0);
        step(0, 1, 32'h4000_0008, 1, 32'h4000_0048);

        // Conflict cycles for the perf counter.
        for (int i = 0; i < 5; i++) step(0, 1, 32'h4000_0300, 1, 32'h4000_0400);
        step(0, 0, 32'h0, 0, 32'h0);

        // Randomized traffic, mostly inside the BIOS region, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, da;
            pc = {(($urandom % 4) != 0) ? 4'h4 : 4'($urandom), 28'($urandom)};
            da = {(($urandom % 4) != 0) ? 4'h4 : 4'($urandom), 28'($urandom)};
            step(($urandom % 60) == 0, ($urandom % 10) < 7, pc, ($urandom % 10) < 7, da);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bios_port_arbiter.md
# bios_port_arbiter

Shares the single synchronous read port of the BIOS memory between the instruction-fetch stage and the data-side load path of the MIPS150 pipeline. Each cycle the block grants the port to at most one requester. It drives the BIOS address and enable, and returns read data with a valid strobe one cycle after the grant. The losing requester receives a stall. The block sits between the IF control/decode logic and the BIOS block RAM, replacing the direct PC-to-BIOS hookup.

## Interface
- `ADDR_W`, default 12: BIOS word-address width.
- `MAX_D_BURST`, default 4: maximum number of consecutive data grants while fetch is waiting; range 1–15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_pc`  in  32  fetch byte address.
- `if_req`  in  1  fetch wants a BIOS read; meaningful only when `if_pc[31:28]==4'b0100`.
- `d_addr`  in  32  load byte address.
- `d_req`  in  1  data side wants a BIOS read; meaningful only when `d_addr[31:28]==4'b0100`.
- `bios_en`  out  1  BIOS read enable.
- `bios_addr`  out  ADDR_W  BIOS word address.
- `bios_dout`  in  32  BIOS read data, valid one cycle after `bios_en`.
- `if_stall`  out  1  fetch request denied this cycle.
- `d_stall`  out  1  data request denied this cycle.
- `if_rvalid`, `d_rvalid`  out  1  read data for that requester is on `rdata` this cycle.
- `rdata`  out  32  routed `bios_dout`.
- `conflict_cnt`  out  16  conflict statistic (see Configuration).

## Operation
- Effective requests:
  - `fq = if_req & (if_pc[31:28]==4'b0100)`
  - `dq = d_req & (d_addr[31:28]==4'b0100)`
- The arbiter is combinational over the registered state. Registered state:
  - `owner` ∈ {IDLE, FETCH, DATA}: the requester granted in the previous cycle.
  - `burst` (4 bits): count of consecutive DATA grants made while `fq` was high.
- Grant rule, in priority order:
  - `dq & ~fq`: DATA.
  - `fq & ~dq`: FETCH.
  - Both asserted: DATA, unless `burst == MAX_D_BURST`, in which case FETCH. Data is given priority because the load is the older instruction.
  - Neither asserted: no grant.
- On a grant:
  - `bios_en = 1`.
  - `bios_addr` = winning address `[ADDR_W+1:2]`.
  - The loser's stall is asserted; both stalls are 0 otherwise.
  - `bios_en = 0` when there is no grant; `bios_addr` is then don't-care and held at the `if_pc` slice.
- `burst` update:
  - Increments on a DATA grant while `fq` is high.
  - Clears on any FETCH grant, and on any cycle with `fq` low.
  - Saturates at `MAX_D_BURST`.
- Next `owner` = this cycle's grant (IDLE if none).
- Read return:
  - `if_rvalid = (owner==FETCH)`, `d_rvalid = (owner==DATA)`.
  - `rdata = bios_dout`, unmodified.
- Back-to-back grants to the same or to alternating requesters are allowed every cycle, with no bubble.
- A requester that sees its stall must hold its request and address. The arbiter does not latch denied requests.

## Timing
- Grant and stall: combinational, in the same cycle as the request.
- Read latency: data is valid exactly 1 cycle after the grant.
- Reset values:
  - Registered state: `owner = IDLE`, `burst = 0`, `conflict_cnt = 0`.
  - Outputs while `reset` is high: `bios_en`, both stalls, both rvalids = 0; `rdata` passes `bios_dout` (don't-care).
- Reset mid-operation: a read granted in the cycle before reset produces no rvalid. Its data is discarded.
- Request dropped after a grant: data still returns with rvalid the next cycle. The requester ignores it.
- Both requests outside the BIOS region: no grant, no stall.

## Configuration
- `BIOS_ARB_PERF_EN`
  - Defined: `conflict_cnt` increments on every cycle with `fq & dq` and saturates at 16'hFFFF. It clears only on reset.
  - Undefined: `conflict_cnt` is constant 0 and the counter logic is omitted.
- Arbitration behaviour is identical either way.

## Test plan
- **Fetch only.** `if_pc=0x40000010`, `if_req=1` for 3 cycles → `bios_en=1`, `bios_addr=0x004` each cycle, `if_rvalid=1` in cycles 2–4, `if_stall=0`.
- **Simultaneous requests.** `d_addr=0x40000020` and `if_pc=0x40000000` in the same cycle → `bios_addr=0x008`, `if_stall=1`, `d_stall=0`; next cycle `d_rvalid=1`, `rdata=mem[8]`.
- **Burst limit.** Both requests held for 6 cycles with `MAX_D_BURST=4` → grants D,D,D,D,F,D; `if_stall` pattern 1,1,1,1,0,1.
- **Region decode.** `if_pc=0x10000000` with `if_req=1`, `d_req=0` → `bios_en=0`, no stall, no rvalid.
- **Reset mid-read.** Data grant in cycle N, `reset=1` in cycle N+1 → `d_rvalid=0` in N+1; `owner` and `burst` cleared.
- **Perf counter.** With `BIOS_ARB_PERF_EN` defined, 5 conflict cycles → `conflict_cnt=5`; with it undefined → `conflict_cnt=0`.
